// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = loader side, slave = byte source / memory side.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Program-image loader: unpacks a length-prefixed big-endian byte stream into instruction memory.
// Optional checksum trailer enabled by defining LOADER_CHKSUM_EN.
module imem_loader #(
  parameter logic [31:0] SIZE = 32'd1024,
  parameter logic [31:0] STEP = 32'd4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err,
  output logic [31:0]   words_ld
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] len_q, len_d;
  logic [31:0] words_ld_q, words_ld_d;
  logic [31:0] addr_q, addr_d;
  logic        in_ready_q, in_ready_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        cpu_hold_q, cpu_hold_d;
`ifdef LOADER_CHKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  logic        accept_s;
  logic        last_byte_s;
  logic [31:0] word_s;

  assign accept_s    = bus.in_valid && in_ready_q;
  assign last_byte_s = accept_s && (byte_cnt_q == 2'd3);
  assign word_s      = {shift_q, bus.in_data};

  // Next-state and next-output computation for the whole loader.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    len_d      = len_q;
    words_ld_d = words_ld_q;
    addr_d     = addr_q;
    in_ready_d = in_ready_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    err_d      = err_q;
    cpu_hold_d = cpu_hold_q;
`ifdef LOADER_CHKSUM_EN
    sum_d      = sum_q;
`endif

    if (accept_s) begin
      shift_d    = {shift_q[15:0], bus.in_data};
      byte_cnt_d = byte_cnt_q + 2'd1;
    end else begin
      shift_d    = shift_q;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN;
          byte_cnt_d = 2'd0;
          words_ld_d = 32'd0;
          addr_d     = 32'd0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          cpu_hold_d = 1'b1;
          in_ready_d = 1'b1;
`ifdef LOADER_CHKSUM_EN
          sum_d      = 32'd0;
`endif
        end else begin
          in_ready_d = 1'b0;
        end
      end
      S_LEN: begin
        if (last_byte_s) begin
          len_d = word_s;
          if (word_s == 32'd0) begin
`ifdef LOADER_CHKSUM_EN
            state_d    = S_CHK;
`else
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
            in_ready_d = 1'b0;
`endif
          end else if (word_s > SIZE) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            in_ready_d = 1'b0;
          end else begin
            state_d    = S_DATA;
          end
        end else begin
          state_d = S_LEN;
        end
      end
      S_DATA: begin
        // in_ready drops only while the final word's write is in flight; release afterwards.
        if (!in_ready_q) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end else if (last_byte_s) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = addr_q;
          wr_data_d  = word_s;
          addr_d     = addr_q + STEP;
          words_ld_d = words_ld_q + 32'd1;
`ifdef LOADER_CHKSUM_EN
          sum_d      = sum_q + word_s;
`endif
          if (words_ld_q + 32'd1 == len_q) begin
`ifdef LOADER_CHKSUM_EN
            state_d    = S_CHK;
`else
            in_ready_d = 1'b0;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef LOADER_CHKSUM_EN
      S_CHK: begin
        if (last_byte_s) begin
          in_ready_d = 1'b0;
          if (word_s == sum_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d    = S_ERR;
            err_d      = 1'b1;
          end
        end else begin
          state_d = S_CHK;
        end
      end
`endif
      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b0;
        cpu_hold_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      len_q      <= 32'd0;
      words_ld_q <= 32'd0;
      addr_q     <= 32'd0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_hold_q <= 1'b1;
`ifdef LOADER_CHKSUM_EN
      sum_q      <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      words_ld_q <= words_ld_d;
      addr_q     <= addr_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_hold_q <= cpu_hold_d;
`ifdef LOADER_CHKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_ld     = words_ld_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomised program images against a
// word-list reference model of the expected memory writes.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [31:0] words_ld;

  imem_loader_if bus ();

  imem_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err),
    .words_ld (words_ld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          t;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  wr_t         wr_log[$];
  logic [7:0]  byte_q[$];
  logic [31:0] img_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) wr_log.push_back('{bus.wr_addr, bus.wr_data, cyc});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    byte_q.push_back(w[31:24]);
    byte_q.push_back(w[23:16]);
    byte_q.push_back(w[15:8]);
    byte_q.push_back(w[7:0]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles each cycle, 2: random stalls plus stray start pulses
  task automatic drive(input int mode, output bit timed_out);
    int idx = 0;
    int n = byte_q.size();
    int budget = 8 * n + 40;
    bit v;
    bit rdy;
    bit tog = 1'b1;
    for (int c = 0; c < budget && idx < n; c++) begin
      case (mode)
        0: v = 1'b1;
        1: begin v = tog; tog = ~tog; end
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? byte_q[idx] : 8'($urandom);
      start        = (mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
      rdy          = bus.in_ready;
      @(posedge clk); #1;
      if (v && rdy === 1'b1) idx++;
    end
    bus.in_valid = 1'b0;
    start        = 1'b0;
    timed_out    = (idx < n);
  endtask

  task automatic wait_end(output bit timed_out);
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1 || err === 1'b1) break;
      @(posedge clk); #1;
    end
    timed_out = !(done === 1'b1 || err === 1'b1);
  endtask

  task automatic load_image(input string tag, input int mode, input bit bad_sum);
    logic [31:0] n;
    logic [31:0] sum;
    bit          to;
    bit          ok;
    int          mism;
    int          spacing;
    int          lim;
    n   = img_q.size();
    sum = 32'd0;
    byte_q.delete();
    wr_log.delete();
    push_word(n);
    foreach (img_q[i]) begin
      push_word(img_q[i]);
      sum += img_q[i];
    end
`ifdef LOADER_CHKSUM_EN
    push_word(bad_sum ? sum + 32'd1 : sum);
    ok = !bad_sum;
`else
    ok = 1'b1;
`endif
    pulse_start();
    drive(mode, to);
    check({tag, "_stream_timeout"}, to, 0);
    wait_end(to);
    check({tag, "_end_timeout"}, to, 0);
    check({tag, "_done"}, done, ok);
    check({tag, "_err"}, err, !ok);
    check({tag, "_cpu_hold"}, cpu_hold, !ok);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_words_ld"}, words_ld, n);
    check({tag, "_wr_count"}, wr_log.size(), n);
    lim = (wr_log.size() < int'(n)) ? wr_log.size() : int'(n);
    mism = 0;
    spacing = 0;
    for (int i = 0; i < lim; i++) begin
      if (wr_log[i].a !== 32'(i) * 32'd4 || wr_log[i].d !== img_q[i]) mism++;
      if (i > 0 && wr_log[i].t - wr_log[i-1].t != 4) spacing++;
      if (i < 2) begin
        check($sformatf("%s_addr%0d", tag, i), wr_log[i].a, 32'(i) * 32'd4);
        check($sformatf("%s_data%0d", tag, i), wr_log[i].d, img_q[i]);
      end
    end
    check({tag, "_wr_mismatches"}, mism, 0);
    if (mode == 0 && n > 1) check({tag, "_b2b_spacing"}, spacing, 0);
  endtask

  task automatic directed_image();
    img_q.delete();
    img_q.push_back(32'h2408_0005);
    img_q.push_back(32'h8C09_0004);
  endtask

  task automatic random_image(input int n);
    img_q.delete();
    for (int i = 0; i < n; i++) img_q.push_back($urandom);
  endtask

  initial begin
    bit to;
    reset        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_words_ld", words_ld, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_in_ready", bus.in_ready, 0);
    check("idle_cpu_hold", cpu_hold, 1);
    check("idle_done", done, 0);
    check("idle_no_writes", wr_log.size(), 0);

    directed_image();
    load_image("dir_b2b", 0, 1'b0);

    // Oversized length: rejected without any write.
    byte_q = '{8'h00, 8'h00, 8'h04, 8'h01};
    wr_log.delete();
    pulse_start();
    drive(0, to);
    check("big_stream_timeout", to, 0);
    wait_end(to);
    check("big_err", err, 1);
    check("big_done", done, 0);
    check("big_cpu_hold", cpu_hold, 1);
    check("big_in_ready", bus.in_ready, 0);
    check("big_no_writes", wr_log.size(), 0);

    random_image(5);
    load_image("after_err", 0, 1'b0);

    directed_image();
    load_image("dir_toggle", 1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      random_image($urandom_range(1, 8));
      load_image($sformatf("rnd%0d", r), $urandom_range(0, 2), 1'b0);
    end

    // Reset after 2 bytes of the first word drops the partial load.
    random_image(3);
    byte_q.delete();
    wr_log.delete();
    push_word(32'd3);
    byte_q.push_back(8'hAA);
    byte_q.push_back(8'h55);
    pulse_start();
    drive(0, to);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_words_ld", words_ld, 0);
    check("midrst_cpu_hold", cpu_hold, 1);
    check("midrst_no_writes", wr_log.size(), 0);
    load_image("post_midrst", 2, 1'b0);

    // Reset while a write is on the bus cancels it on the next cycle.
    byte_q.delete();
    push_word(32'd2);
    push_word(32'hDEAD_BEEF);
    pulse_start();
    drive(0, to);
    check("inflight_wr_en", bus.wr_en, 1);
    check("inflight_wr_data", bus.wr_data, 32'hDEAD_BEEF);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("inflight_rst_wr_en", bus.wr_en, 0);
    check("inflight_rst_words_ld", words_ld, 0);

    img_q.delete();
    load_image("zero_len", 0, 1'b0);

    random_image(1024);
    load_image("max_len", 0, 1'b0);
    check("max_last_addr", (wr_log.size() == 1024) ? wr_log[1023].a : 32'hFFFF_FFFF, 32'h0000_0FFC);

`ifdef LOADER_CHKSUM_EN
    directed_image();
    load_image("chk_bad", 0, 1'b1);
    directed_image();
    load_image("chk_good", 0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
